ssrv_perf_mon: RTL and testbench



---
 rtl/ssrv_perf_mon.sv | 114 +++++++++++
 tb/tb_ssrv_perf_mon.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/ssrv_perf_mon.sv
// Performance monitor beside ssrv_top: counts ticks, retired instructions, jumps,
// data-memory requests and an issue-width histogram over a CSR-delimited window.
module ssrv_perf_mon #(
  parameter int         EXEC_LEN  = 4,
  parameter int         CNT_W     = 32,
  parameter logic [2:0] TRIG_MASK = 3'b111
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [EXEC_LEN-1:0] exec_vld,
  input  logic                jump_vld,
  input  logic                dmem_req,
  input  logic                csr_vld,
  input  logic [11:0]         csr_addr,
  input  logic                clear,
  input  logic [4:0]          rd_sel,
  output logic [CNT_W-1:0]    rd_data,
  output logic                running,
  output logic                done
);

  localparam int PC_W = $clog2(EXEC_LEN + 1);
  // Counter bank order: tick, instr, jump, mem, then hist[0..EXEC_LEN].
  localparam int NCNT = 5 + EXEC_LEN;

  // state  | meaning
  // S_IDLE | waiting for start trigger
  // S_RUN  | window open, counting every cycle
  // S_DONE | window closed, counters frozen until rst/clear
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_next;
  logic              w_trig;
  logic [PC_W-1:0]   w_pc;
  logic [CNT_W-1:0]  r_cnt [NCNT];
  logic [CNT_W-1:0]  w_inc [NCNT];
  logic [CNT_W-1:0]  w_sum [NCNT];
  logic [NCNT-1:0]   w_sat;
  logic              r_ovf;
  logic [CNT_W-1:0]  w_rd;

  assign w_trig = csr_vld & ((TRIG_MASK[0] & (csr_addr == 12'hc00)) |
                             (TRIG_MASK[1] & (csr_addr == 12'hc01)) |
                             (TRIG_MASK[2] & (csr_addr == 12'hc80)));

  always_comb begin
    w_pc = '0;
    for (int i = 0; i < EXEC_LEN; i++) w_pc = w_pc + PC_W'(exec_vld[i]);
  end

  always_comb begin
    w_inc[0] = CNT_W'(1);
    w_inc[1] = CNT_W'(w_pc);
    w_inc[2] = CNT_W'(jump_vld);
    w_inc[3] = CNT_W'(dmem_req);
    for (int k = 0; k <= EXEC_LEN; k++) w_inc[4+k] = CNT_W'(w_pc == PC_W'(k));
  end

  // Saturating add: the carry out of a one-bit-wider sum flags the saturation event.
  always_comb begin
    w_sat = '0;
    for (int i = 0; i < NCNT; i++) begin
      {w_sat[i], w_sum[i]} = {1'b0, r_cnt[i]} + {1'b0, w_inc[i]};
      if (w_sat[i]) w_sum[i] = '1;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_trig) w_next = S_RUN;
      S_RUN:   if (w_trig) w_next = S_DONE;
      S_DONE:  w_next = S_DONE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    w_rd = '0;
    if (rd_sel == 5'd4) w_rd = {{(CNT_W-3){1'b0}}, r_ovf, done, running};
    for (int i = 0; i < NCNT; i++) begin
      if (rd_sel == 5'((i < 4) ? i : i + 1)) w_rd = r_cnt[i];
    end
  end

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      r_state <= S_IDLE;
      running <= 1'b0;
      done    <= 1'b0;
      r_ovf   <= 1'b0;
      rd_data <= '0;
      for (int i = 0; i < NCNT; i++) r_cnt[i] <= '0;
    end else begin
      r_state <= w_next;
      running <= (w_next == S_RUN);
      done    <= (w_next == S_DONE);
      rd_data <= w_rd;
      if (r_state == S_IDLE && w_trig) begin
        r_ovf <= 1'b0;
        for (int i = 0; i < NCNT; i++) r_cnt[i] <= '0;
      end else if (r_state == S_RUN) begin
        if (|w_sat) r_ovf <= 1'b1;
        for (int i = 0; i < NCNT; i++) r_cnt[i] <= w_sum[i];
      end
    end
  end

endmodule

// File: tb/tb_ssrv_perf_mon.sv
// Scoreboard bench for ssrv_perf_mon: u_dut0 (CNT_W=8, all triggers) and
// u_dut1 (only c80 triggers) share stimulus; reads push expectations, a monitor checks.
module tb_ssrv_perf_mon;

  logic       clk = 1'b0;
  logic       rst, jump_vld, dmem_req, csr_vld, clear;
  logic [3:0] exec_vld;
  logic [11:0] csr_addr;
  logic [4:0] rd_sel;
  logic [7:0] rd0, rd1;
  logic       run0, done0, run1, done1;

  always #5 clk = ~clk;

  ssrv_perf_mon #(.EXEC_LEN(4), .CNT_W(8), .TRIG_MASK(3'b111)) u_dut0 (
    .clk(clk), .rst(rst), .exec_vld(exec_vld), .jump_vld(jump_vld), .dmem_req(dmem_req),
    .csr_vld(csr_vld), .csr_addr(csr_addr), .clear(clear), .rd_sel(rd_sel),
    .rd_data(rd0), .running(run0), .done(done0));

  ssrv_perf_mon #(.EXEC_LEN(4), .CNT_W(8), .TRIG_MASK(3'b100)) u_dut1 (
    .clk(clk), .rst(rst), .exec_vld(exec_vld), .jump_vld(jump_vld), .dmem_req(dmem_req),
    .csr_vld(csr_vld), .csr_addr(csr_addr), .clear(clear), .rd_sel(5'd4),
    .rd_data(rd1), .running(run1), .done(done1));

  typedef struct {
    logic [7:0] d;
    logic       r0;
    logic       d0;
    logic       r1;
    string      nm;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad = 0;
  logic rd_req = 1'b0;
  logic rd_req_d = 1'b0;

  always @(posedge clk) rd_req_d <= rd_req;

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    if (rd_req_d) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL sb_underflow: got read with empty queue want entry");
      end else begin
        e = sb.pop_front();
        chk(e.nm, rd0, e.d);
        chk({e.nm, "_running"}, 8'(run0), 8'(e.r0));
        chk({e.nm, "_done"}, 8'(done0), 8'(e.d0));
        chk({e.nm, "_running1"}, 8'(run1), 8'(e.r1));
        chk({e.nm, "_status1"}, rd1, 8'(e.r1));
        chk({e.nm, "_done1"}, 8'(done1), 8'h00);
      end
    end
  end

  task automatic cyc(input logic [3:0] ev, input logic j, input logic m,
                     input logic [11:0] addr, input logic clr);
    exec_vld = ev;
    jump_vld = j;
    dmem_req = m;
    csr_vld  = (addr != 12'h000);
    csr_addr = addr;
    clear    = clr;
    rd_req   = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input logic [4:0] sel, input logic [7:0] d, input logic r0,
                    input logic d0, input logic r1, input string nm);
    exp_t e;
    exec_vld = '0;
    jump_vld = 1'b0;
    dmem_req = 1'b0;
    csr_vld  = 1'b0;
    csr_addr = '0;
    clear    = 1'b0;
    rd_sel   = sel;
    rd_req   = 1'b1;
    e.d = d; e.r0 = r0; e.d0 = d0; e.r1 = r1; e.nm = nm;
    sb.push_back(e);
    @(posedge clk);
    #1;
    rd_req = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; exec_vld = '0; jump_vld = 1'b0; dmem_req = 1'b0;
    csr_vld = 1'b0; csr_addr = '0; clear = 1'b0; rd_sel = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    for (int i = 0; i <= 10; i++) rd(5'(i), 8'd0, 0, 0, 0, $sformatf("reset_rd%0d", i));
    rd(5'd31, 8'd0, 0, 0, 0, "reset_rd31");

    // Main window: start c00, 10 busy cycles, stop c80 with no retires.
    cyc(4'b0000, 0, 0, 12'hc00, 0);
    for (int i = 0; i < 10; i++) cyc(4'b1011, (i < 3), (i < 5), 12'h000, 0);
    cyc(4'b0000, 0, 0, 12'hc80, 0);
    rd(5'd0, 8'd11, 0, 1, 1, "win_tick");
    rd(5'd1, 8'd30, 0, 1, 1, "win_instr");
    rd(5'd2, 8'd3,  0, 1, 1, "win_jump");
    rd(5'd3, 8'd5,  0, 1, 1, "win_mem");
    rd(5'd4, 8'd2,  0, 1, 1, "win_status");
    rd(5'd5, 8'd1,  0, 1, 1, "win_hist0");
    rd(5'd6, 8'd0,  0, 1, 1, "win_hist1");
    rd(5'd8, 8'd10, 0, 1, 1, "win_hist3");
    rd(5'd9, 8'd0,  0, 1, 1, "win_hist4");

    // Trigger while DONE is ignored; c01 is masked on u_dut1.
    cyc(4'b1111, 1, 1, 12'hc01, 0);
    rd(5'd0, 8'd11, 0, 1, 1, "done_trig_tick");
    rd(5'd1, 8'd30, 0, 1, 1, "done_trig_instr");

    // Back-to-back triggers: exactly one counted cycle.
    cyc(4'b0000, 0, 0, 12'h000, 1);
    cyc(4'b1111, 0, 0, 12'hc00, 0);
    cyc(4'b1111, 0, 0, 12'hc80, 0);
    rd(5'd0, 8'd1, 0, 1, 1, "b2b_tick");
    rd(5'd1, 8'd4, 0, 1, 1, "b2b_instr");
    rd(5'd9, 8'd1, 0, 1, 1, "b2b_hist4");
    rd(5'd5, 8'd0, 0, 1, 1, "b2b_hist0");
    rd(5'd4, 8'd2, 0, 1, 1, "b2b_status");

    // Clear in the same cycle as a start trigger wins.
    cyc(4'b0000, 0, 0, 12'hc00, 1);
    rd(5'd0, 8'd0, 0, 0, 0, "clr_start_tick");
    rd(5'd4, 8'd0, 0, 0, 0, "clr_start_status");

    // 300 counted cycles saturate the 8-bit counters.
    cyc(4'b0000, 0, 0, 12'hc00, 0);
    for (int i = 0; i < 299; i++) cyc(4'b0001, 0, 0, 12'h000, 0);
    cyc(4'b0001, 0, 0, 12'hc80, 0);
    rd(5'd0, 8'd255, 0, 1, 1, "sat_tick");
    rd(5'd1, 8'd255, 0, 1, 1, "sat_instr");
    rd(5'd6, 8'd255, 0, 1, 1, "sat_hist1");
    rd(5'd5, 8'd0,   0, 1, 1, "sat_hist0");
    rd(5'd2, 8'd0,   0, 1, 1, "sat_jump");
    rd(5'd4, 8'd6,   0, 1, 1, "sat_status");
    cyc(4'b0000, 0, 0, 12'h000, 1);
    rd(5'd0, 8'd0, 0, 0, 0, "sat_clr_tick");
    rd(5'd6, 8'd0, 0, 0, 0, "sat_clr_hist1");
    rd(5'd4, 8'd0, 0, 0, 0, "sat_clr_status");

    // Clear mid-window aborts it.
    cyc(4'b0000, 0, 0, 12'hc00, 0);
    repeat (3) cyc(4'b1111, 1, 1, 12'h000, 0);
    cyc(4'b0000, 0, 0, 12'h000, 1);
    rd(5'd0, 8'd0, 0, 0, 0, "abort_tick");
    rd(5'd1, 8'd0, 0, 0, 0, "abort_instr");
    rd(5'd4, 8'd0, 0, 0, 0, "abort_status");

    // c01 starts u_dut0 but not u_dut1; read cycles count as idle cycles.
    cyc(4'b0000, 0, 0, 12'hc01, 0);
    rd(5'd4, 8'd1, 1, 0, 0, "c01_status");
    rd(5'd0, 8'd1, 1, 0, 0, "c01_tick");
    rd(5'd5, 8'd2, 1, 0, 0, "c01_hist0");

    repeat (2) @(posedge clk);
    #1;
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL sb_drain: got %0d pending want 0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
